// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package sevenseg_pkg;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex digit to {g,f,e,d,c,b,a}, active-low; entry 0 is the digit '0'.
    localparam logic [0:15][6:0] HEX_SEG_TBL = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sevenseg_scan_if.sv
// Display bus: the master drives scan strobe and display data, the slave
// drives the anode/segment pins.
interface sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      scan_in;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp_n;

    modport master (
        output scan_in, value, dp, blank,
        input  an, seg, dp_n
    );

    modport slave (
        input  scan_in, value, dp, blank,
        output an, seg, dp_n
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX_SEG_TBL[nib];
endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: steps one digit per rising edge of the
// slow scan strobe, blanks the anodes for DEAD_CYCLES after each step, and
// latches display data once per frame on the wrap back to digit 0.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic           clk_in,
    input  logic           reset,
    sevenseg_scan_if.slave bus
);
    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT  = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;
    localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(NUM_DIGITS - 1);
    localparam state_e           ST_RESET  = (DEAD_CYCLES > 0) ? ST_DEAD : ST_DRIVE;

    state_e                    state_q, state_d;
    logic [DIG_W-1:0]          digit_q, digit_d;
    logic [CNT_W-1:0]          dead_cnt_q, dead_cnt_d;
    logic                      scan_q, scan_d;
    logic [4*NUM_DIGITS-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0]     dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     blank_q, blank_d;
    logic                      rise;
    logic [3:0]                nib;
    logic [6:0]                dec_seg;

    // State register; scan_q resets high so a strobe already high at release is not an edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_RESET;
            digit_q    <= '0;
            dead_cnt_q <= CNT_INIT;
            scan_q     <= 1'b1;
            value_q    <= '0;
            dp_q       <= '0;
            blank_q    <= '1;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            dead_cnt_q <= dead_cnt_d;
            scan_q     <= scan_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
        end
    end

    // Next-state: digit stepping, dead-time countdown, frame latch on wrap.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        dead_cnt_d = dead_cnt_q;
        value_d    = value_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        scan_d     = bus.scan_in;
        rise       = bus.scan_in & ~scan_q;
        case (state_q)
            ST_DRIVE: begin
                if (rise) begin
                    if (digit_q == LAST_DIG) begin
                        digit_d = '0;
                        value_d = bus.value;
                        dp_d    = bus.dp;
                        blank_d = bus.blank;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                    if (DEAD_CYCLES > 0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = CNT_INIT;
                    end
                end
            end
            default: begin
                // Rises during dead time are dropped on purpose.
                if (dead_cnt_q == '0) state_d = ST_DRIVE;
                else                  dead_cnt_d = dead_cnt_q - 1'b1;
            end
        endcase
    end

    assign nib = value_q[4*digit_q +: 4];

    hex7seg u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Output decode from registered state only.
    always_comb begin
        bus.an   = '1;
        bus.seg  = SEG_OFF;
        bus.dp_n = 1'b1;
        if (state_q == ST_DRIVE && !blank_q[digit_q]) begin
            bus.an   = ~(NUM_DIGITS'(1) << digit_q);
            bus.seg  = dec_seg;
            bus.dp_n = ~dp_q[digit_q];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: three instances (dead time 2, 0, 4) share one
// stimulus stream and are compared every cycle against a time-based model.
module tb_sevenseg_scan;
    localparam int ND = 4;

    logic        clk_in = 1'b0;
    logic        reset_r;
    logic        scan_r;
    logic [15:0] value_r;
    logic [3:0]  dp_r, blank_r;

    always #5 clk_in = ~clk_in;

    sevenseg_scan_if #(.NUM_DIGITS(ND)) if0 ();
    sevenseg_scan_if #(.NUM_DIGITS(ND)) if1 ();
    sevenseg_scan_if #(.NUM_DIGITS(ND)) if2 ();

    assign if0.scan_in = scan_r;  assign if0.value = value_r;  assign if0.dp = dp_r;  assign if0.blank = blank_r;
    assign if1.scan_in = scan_r;  assign if1.value = value_r;  assign if1.dp = dp_r;  assign if1.blank = blank_r;
    assign if2.scan_in = scan_r;  assign if2.value = value_r;  assign if2.dp = dp_r;  assign if2.blank = blank_r;

    sevenseg_scan #(.NUM_DIGITS(ND), .DEAD_CYCLES(2)) u_dc2 (.clk_in(clk_in), .reset(reset_r), .bus(if0));
    sevenseg_scan #(.NUM_DIGITS(ND), .DEAD_CYCLES(0)) u_dc0 (.clk_in(clk_in), .reset(reset_r), .bus(if1));
    sevenseg_scan #(.NUM_DIGITS(ND), .DEAD_CYCLES(4)) u_dc4 (.clk_in(clk_in), .reset(reset_r), .bus(if2));

    logic [3:0] an_o  [3];
    logic [6:0] seg_o [3];
    logic       dpn_o [3];
    assign an_o[0] = if0.an;  assign seg_o[0] = if0.seg;  assign dpn_o[0] = if0.dp_n;
    assign an_o[1] = if1.an;  assign seg_o[1] = if1.seg;  assign dpn_o[1] = if1.dp_n;
    assign an_o[2] = if2.an;  assign seg_o[2] = if2.seg;  assign dpn_o[2] = if2.dp_n;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Reference model: a step accepted at edge e keeps the outputs dark for
    // the DEAD_CYCLES states following edge e; reset behaves like a step at
    // the reset edge with digit 0 and a fully blanked frame.
    int          dcv [3] = '{2, 0, 4};
    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          edge_k = 0;
    int          last_step [3];
    int          steps [3];
    logic [15:0] vq [3];
    logic [3:0]  dq [3], bq [3];
    bit          sprev = 1'b1;

    task automatic model_edge();
        bit rise;
        edge_k++;
        if (reset_r) begin
            sprev = 1'b1;
            for (int i = 0; i < 3; i++) begin
                last_step[i] = edge_k;  steps[i] = 0;
                vq[i] = '0;  dq[i] = '0;  bq[i] = '1;
            end
        end else begin
            rise  = scan_r && !sprev;
            sprev = scan_r;
            for (int i = 0; i < 3; i++) begin
                if (rise && (edge_k - 1 - last_step[i]) >= dcv[i]) begin
                    steps[i]++;
                    last_step[i] = edge_k;
                    if (steps[i] % ND == 0) begin
                        vq[i] = value_r;  dq[i] = dp_r;  bq[i] = blank_r;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        int d;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        for (int i = 0; i < 3; i++) begin
            d = steps[i] % ND;
            if ((edge_k - last_step[i]) < dcv[i] || bq[i][d]) begin
                ean = 4'hF;  eseg = 7'h7F;  edp = 1'b1;
            end else begin
                ean  = ~(4'b0001 << d);
                eseg = seg_tbl[vq[i][4*d +: 4]];
                edp  = ~dq[i][d];
            end
            chk($sformatf("dc%0d_an@%0d", dcv[i], edge_k), 32'(an_o[i]), 32'(ean));
            chk($sformatf("dc%0d_seg@%0d", dcv[i], edge_k), 32'(seg_o[i]), 32'(eseg));
            chk($sformatf("dc%0d_dpn@%0d", dcv[i], edge_k), 32'(dpn_o[i]), 32'(edp));
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        reset_r = 1'b1;  scan_r = 1'b1;  value_r = '0;  dp_r = '0;  blank_r = '0;

        // Reset with the strobe already high, then idle: nothing may light.
        repeat (3) tick();
        reset_r = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("idle_an", 32'(an_o[0]), 32'hF);
        end

        // Periodic strobe, period 8; data swap mid-frame, then dp/blank.
        value_r = 16'h1234;
        for (int c = 0; c < 600; c++) begin
            scan_r = (c % 8) < 4;
            if (c == 150) value_r = 16'hABCD;
            if (c == 300) begin dp_r = 4'b0001; blank_r = 4'b0100; end
            tick();
        end

        // Short reset mid-scan, then periodic again.
        reset_r = 1'b1;  tick();  reset_r = 1'b0;
        chk("rst_an", 32'(an_o[0]), 32'hF);
        for (int c = 0; c < 200; c++) begin
            scan_r = (c % 6) < 3;
            tick();
        end

        // Random strobe (includes rises inside dead time), random data and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) scan_r = ~scan_r;
            if ($urandom_range(0, 40) == 0) value_r = 16'($urandom);
            if ($urandom_range(0, 60) == 0) dp_r    = 4'($urandom);
            if ($urandom_range(0, 60) == 0) blank_r = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            reset_r = ($urandom_range(0, 400) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
